// File: rtl/branch_resolve.sv
// Branch resolution: compares each resolved branch with its frontend
// prediction, tracks the oldest outstanding mispredict by ROB age, and
// raises a backend flush plus a held frontend redirect when that branch
// commits. Also emits a registered predictor-update pulse per branch.
module branch_resolve #(
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic                 br_taken,
  input  logic                 br_pred_taken,
  input  logic [31:0]          br_pc,
  input  logic [31:0]          br_target,
  input  logic [31:0]          br_pred_target,
  input  logic [ROB_IDX_W:0]   br_rob_id,
  input  logic [ROB_IDX_W:0]   rob_head,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W:0]   commit_rob_id,
  output logic                 flush,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  output logic [31:0]          upd_pc,
  output logic                 upd_taken
);

  localparam int TAG_W = ROB_IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   pend_tag, pend_tag_nxt;
  logic [31:0]        pend_pc, pend_pc_nxt;
  logic [31:0]        redirect_pc_nxt;
  logic               flush_nxt;
  logic               mispredict;
  logic [31:0]        correct_pc;
  logic               new_is_older;

  // Distance from the ROB head; the phase bit makes the modular
  // subtraction order tags correctly across wrap-around.
  function automatic logic [TAG_W-1:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
    return tag - head;
  endfunction

  assign mispredict   = br_valid &&
                        ((br_taken != br_pred_taken) ||
                         (br_taken && (br_target != br_pred_target)));
  assign correct_pc   = br_taken ? br_target : (br_pc + 32'd4);
  assign new_is_older = rob_age(br_rob_id, rob_head) < rob_age(pend_tag, rob_head);

  // Next-state logic: latch the oldest mispredict, fire on its commit,
  // then hold the redirect until the frontend takes it.
  always_comb begin
    state_nxt       = state;
    pend_tag_nxt    = pend_tag;
    pend_pc_nxt     = pend_pc;
    redirect_pc_nxt = redirect_pc;
    flush_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) begin
          pend_tag_nxt = br_rob_id;
          pend_pc_nxt  = correct_pc;
          state_nxt    = PENDING;
        end
      end
      PENDING: begin
        if (commit_valid && (commit_rob_id == pend_tag)) begin
          // Same-cycle branches are younger than a committing one and are
          // about to be squashed, so they are dropped here.
          flush_nxt       = 1'b1;
          redirect_pc_nxt = pend_pc;
          state_nxt       = REDIRECT;
        end else if (mispredict && new_is_older) begin
          pend_tag_nxt = br_rob_id;
          pend_pc_nxt  = correct_pc;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, redirect and predictor-update registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_tag    <= '0;
      pend_pc     <= '0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_tag    <= pend_tag_nxt;
      pend_pc     <= pend_pc_nxt;
      redirect_pc <= redirect_pc_nxt;
      flush       <= flush_nxt;
      // Update is suppressed on the flush cycle so the predictor never
      // trains on a branch that is being squashed alongside the flush.
      upd_valid   <= br_valid && !flush_nxt;
      if (br_valid) begin
        upd_pc    <= br_pc;
        upd_taken <= br_taken;
      end
    end
  end

  assign redirect_valid = (state == REDIRECT);

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_branch_resolve;

  localparam int ROB_IDX_W = 4;
  localparam int TAGS      = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                br_valid, br_taken, br_pred_taken;
  logic [31:0]         br_pc, br_target, br_pred_target;
  logic [ROB_IDX_W:0]  br_rob_id, rob_head, commit_rob_id;
  logic                commit_valid, redirect_ready;
  logic                flush, redirect_valid, upd_valid, upd_taken;
  logic [31:0]         redirect_pc, upd_pc;

  int passed = 0;
  int total  = 0;

  // Reference model state
  bit          m_pend, m_redir;
  int          m_ptag;
  logic [31:0] m_ppc;
  logic        exp_flush, exp_rv, exp_uv, exp_ut;
  logic [31:0] exp_rpc, exp_upc;

  always #5 clk = ~clk;

  branch_resolve #(.ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_taken(br_taken), .br_pred_taken(br_pred_taken),
    .br_pc(br_pc), .br_target(br_target), .br_pred_target(br_pred_target),
    .br_rob_id(br_rob_id), .rob_head(rob_head),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken)
  );

  function automatic int age(input int tag, input int head);
    return (tag - head + TAGS) % TAGS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_update();
    bit          mis;
    logic [31:0] cpc;
    bit          nf;
    nf  = 0;
    mis = br_valid && ((br_taken != br_pred_taken) ||
                       (br_taken && br_target != br_pred_target));
    cpc = br_taken ? br_target : br_pc + 32'd4;
    if (rst) begin
      m_pend = 0; m_redir = 0;
      exp_rpc = 0; exp_upc = 0; exp_ut = 0; exp_uv = 0;
    end else begin
      if (m_redir) begin
        if (redirect_ready) m_redir = 0;
      end else if (m_pend) begin
        if (commit_valid && int'(commit_rob_id) == m_ptag) begin
          nf = 1; m_redir = 1; m_pend = 0; exp_rpc = m_ppc;
        end else if (mis && age(int'(br_rob_id), int'(rob_head)) < age(m_ptag, int'(rob_head))) begin
          m_ptag = int'(br_rob_id); m_ppc = cpc;
        end
      end else if (mis) begin
        m_pend = 1; m_ptag = int'(br_rob_id); m_ppc = cpc;
      end
      exp_uv = br_valid && !nf;
      if (br_valid) begin
        exp_upc = br_pc; exp_ut = br_taken;
      end
    end
    exp_flush = nf;
    exp_rv    = m_redir;
  endtask

  task automatic check_all();
    check("flush", {31'd0, flush}, {31'd0, exp_flush});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
    check("upd_valid", {31'd0, upd_valid}, {31'd0, exp_uv});
    if (exp_rv) check("redirect_pc", redirect_pc, exp_rpc);
    if (exp_uv) begin
      check("upd_pc", upd_pc, exp_upc);
      check("upd_taken", {31'd0, upd_taken}, {31'd0, exp_ut});
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic br(input logic tk, input logic pr, input logic [31:0] pc,
                    input logic [31:0] tg, input logic [31:0] ptg, input int id);
    br_valid = 1; br_taken = tk; br_pred_taken = pr;
    br_pc = pc; br_target = tg; br_pred_target = ptg;
    br_rob_id = id[ROB_IDX_W:0];
  endtask

  task automatic quiet();
    br_valid = 0; commit_valid = 0; redirect_ready = 0;
  endtask

  task automatic commit(input int id);
    commit_valid = 1; commit_rob_id = id[ROB_IDX_W:0];
  endtask

  initial begin
    rst = 1; br_valid = 0; br_taken = 0; br_pred_taken = 0;
    br_pc = 0; br_target = 0; br_pred_target = 0; br_rob_id = 0;
    rob_head = 0; commit_valid = 0; commit_rob_id = 0; redirect_ready = 0;
    m_pend = 0; m_redir = 0; m_ptag = 0; m_ppc = 0;
    exp_flush = 0; exp_rv = 0; exp_uv = 0; exp_ut = 0; exp_rpc = 0; exp_upc = 0;

    // Reset state
    step(); step();
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_upd_pc", upd_pc, 32'h0);
    check("rst_upd_taken", {31'd0, upd_taken}, 32'h0);
    rst = 0;

    // 1: correctly predicted taken branch only trains the predictor
    br(1, 1, 32'h1000, 32'h100, 32'h100, 2);
    step();
    check("t1_upd_valid", {31'd0, upd_valid}, 32'h1);
    check("t1_upd_pc", upd_pc, 32'h1000);
    quiet();
    step();
    commit(2);
    step();
    check("t1_no_flush", {31'd0, flush}, 32'h0);
    quiet();

    // 2: direction mispredict, redirect held while frontend stalls
    br(0, 1, 32'h40, 32'h0, 32'h0, 3);
    step();
    quiet();
    step();
    commit(3);
    step();
    check("t2_flush", {31'd0, flush}, 32'h1);
    check("t2_upd_blocked", {31'd0, upd_valid}, 32'h0);
    check("t2_redirect_pc", redirect_pc, 32'h44);
    quiet();
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_valid", {31'd0, redirect_valid}, 32'h1);
      check("t2_hold_pc", redirect_pc, 32'h44);
    end
    redirect_ready = 1;
    step();
    check("t2_drop", {31'd0, redirect_valid}, 32'h0);
    quiet();

    // 3: phase-wrap age compare keeps the older tag 15 over 17
    rob_head = 5'd14;
    br(0, 1, 32'h2000, 32'h0, 32'h0, 17);
    step();
    br(1, 0, 32'h3000, 32'h3400, 32'h0, 15);
    step();
    quiet();
    commit(17);
    step();
    check("t3_no_flush_17", {31'd0, flush}, 32'h0);
    commit(15);
    step();
    check("t3_flush_15", {31'd0, flush}, 32'h1);
    check("t3_redirect_pc", redirect_pc, 32'h3400);
    quiet();
    redirect_ready = 1;
    step();
    quiet();

    // 4: target-only mispredict
    rob_head = 0;
    br(1, 1, 32'h500, 32'h200, 32'h300, 5);
    step();
    quiet();
    commit(5);
    step();
    check("t4_redirect_pc", redirect_pc, 32'h200);
    quiet();
    redirect_ready = 1;
    step();
    quiet();

    // 5: mispredict arriving with the commit is discarded
    br(0, 1, 32'h80, 32'h0, 32'h0, 7);
    step();
    commit(7);
    br(1, 0, 32'h90, 32'h600, 32'h0, 6);
    step();
    check("t5_flush", {31'd0, flush}, 32'h1);
    check("t5_redirect_pc", redirect_pc, 32'h84);
    quiet();
    redirect_ready = 1;
    step();
    quiet();
    commit(6);
    step();
    check("t5_dropped", {31'd0, flush}, 32'h0);
    quiet();

    // 6: reset during a held redirect
    br(0, 1, 32'h700, 32'h0, 32'h0, 2);
    step();
    quiet();
    commit(2);
    step();
    quiet();
    step();
    rst = 1;
    br(1, 1, 32'h800, 32'h10, 32'h10, 4);
    step();
    check("t6_rv", {31'd0, redirect_valid}, 32'h0);
    check("t6_flush", {31'd0, flush}, 32'h0);
    check("t6_upd", {31'd0, upd_valid}, 32'h0);
    rst = 0;
    quiet();
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) rob_head = rob_head + 5'd1;
      br_valid       = $urandom_range(0, 1);
      br_taken       = $urandom_range(0, 1);
      br_pred_taken  = ($urandom_range(0, 3) == 0) ? ~br_taken : br_taken;
      br_pc          = $urandom & 32'hFFFF_FFFC;
      br_target      = $urandom & 32'hFFFF_FFFC;
      br_pred_target = ($urandom_range(0, 3) == 0) ? br_target ^ 32'h40 : br_target;
      br_rob_id      = rob_head + 5'($urandom_range(0, 15));
      commit_valid   = $urandom_range(0, 1);
      if (m_pend && $urandom_range(0, 2) == 0)
        commit_rob_id = m_ptag[ROB_IDX_W:0];
      else
        commit_rob_id = 5'($urandom_range(0, TAGS - 1));
      redirect_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
